poly_basemul_seq: RTL
=====================

Name: poly_basemul_seq

Overview:
Sequencer that drives a basemul instance across a whole Kyber polynomial pair in the NTT domain. It is the initiator for basemul, which is the responder.
- Reads coefficient pairs of a and b from two coefficient RAMs.
- Presents each pair with the correct ±zeta and issues basemul start.
- Waits the fixed basemul latency, then writes the result pair to the result RAM.
- Sits between the polynomial RAM bank and the basemul datapath in the NTT multiply stage.

Parameters:
- BM_LATENCY, 13: cycles from the cycle bm_start is high to the cycle bm_r is valid and stable.
- NPAIRS, 128: coefficient pairs per polynomial (256 coefficients / 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to process one polynomial pair
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last write
- a_rd_addr  out  7  pair index into RAM A; synchronous read, 1-cycle latency
- a_rd_data  in  2x16 signed  {a[0],a[1]}
- b_rd_addr  out  7  pair index into RAM B
- b_rd_data  in  2x16 signed  {b[0],b[1]}
- r_wr_en  out  1  result write strobe
- r_wr_addr  out  7  result pair index
- r_wr_data  out  2x16 signed  result pair
- bm_start  out  1  basemul start
- bm_a  out  2x16 signed  operand a to basemul
- bm_b  out  2x16 signed  operand b to basemul
- bm_zeta  out  16 signed  zeta to basemul
- bm_r  in  2x16 signed  basemul result

Behaviour:
- Clocking: single clock clk. rst is asynchronous and active-high. All outputs are registered.
- Reset values: state=IDLE; busy, done, r_wr_en and bm_start = 0; all addresses, data, bm_a, bm_b and bm_zeta = 0; pair counter k = 0.
- FSM states: IDLE, READ, LOAD, WAIT, WRITE, FIN.
  - IDLE: start=1 → READ, k=0, busy=1. Otherwise stay.
  - READ: drive a_rd_addr = b_rd_addr = k → LOAD.
  - LOAD: register a_rd_data→bm_a and b_rd_data→bm_b. Set bm_zeta = (k[0]==0) ? ZETAS[64+k>>1] : -ZETAS[64+k>>1]. Assert bm_start for exactly one cycle, load the wait counter with BM_LATENCY → WAIT.
  - WAIT: decrement the counter each cycle. Hold bm_a, bm_b and bm_zeta stable. Leave at 0 → WRITE.
  - WRITE: r_wr_en=1 for one cycle, r_wr_addr=k, r_wr_data=bm_r. If k==NPAIRS-1 → FIN, else k+1 → READ.
  - FIN: done=1 for one cycle, busy=0 → IDLE.
- Latency: (BM_LATENCY+3) cycles per pair. The done pulse comes NPAIRS·(BM_LATENCY+3)+1 cycles after the start cycle.
- start while busy: ignored, no restart.
- start in the same cycle as done (FIN): ignored. It is accepted the following cycle in IDLE.
- Zeta negation: 16-bit two's complement. |ZETAS| < 3329, so no overflow.
- k wraps only via FIN. Addresses never exceed NPAIRS-1.
- rst mid-operation: immediate return to IDLE with reset values.
  - No write strobe is generated after rst asserts.
  - A partially written result RAM is the caller's problem.

Optional Feature:
- Macro: BASEMUL_ACC_EN.
- Defined:
  - Adds ports acc (in, 1), r_rd_addr (out, 7) and r_rd_data (in, 2x16 signed).
  - acc is sampled on the accepted start.
  - If acc=1: READ also drives r_rd_addr=k, and LOAD registers r_rd_data.
  - WRITE then produces r_wr_data[i] = r_old[i] + bm_r[i], 16-bit wrapping add with no reduction. Barrett reduction happens downstream.
  - If acc=0: identical to the macro-undefined behaviour.
- Undefined: the extra ports are absent and writes are plain overwrite.

Decomposition:
- Shared package kyber_pkg holds:
  - KYBER_Q=3329, KYBER_N=256
  - typedef coeff_t (signed 16-bit)
  - ZETAS[128] Montgomery-domain table (entries 64..127 used here)
  - FSM state enum
- One natural sub-module: zeta_sel. Combinational (k → ±zeta). Kept separate so the NTT/INTT controllers can reuse the table indexing.
- The basemul instance is outside this block.

Test Plan:
1. a=b=all pairs {1,0}, basemul stub returning {a0b0, a0b1+a1b0} after BM_LATENCY → 128 writes of {1,0}; addresses 0..127 in order; done at cycle 128·16+1 after start.
2. Monitor bm_zeta: k=0 → ZETAS[64], k=1 → −ZETAS[64], k=127 → −ZETAS[127]; values stable throughout WAIT.
3. Real basemul plus random a,b, compared against C reference poly_basemul_montgomery → all 256 coefficients bit-exact.
4. Second start pulsed at cycle 50 of a run → ignored; exactly 128 writes and a single done.
5. rst asserted during WAIT of k=40 → busy, r_wr_en and bm_start go 0 asynchronously; no further writes; new start restarts at k=0.
6. BASEMUL_ACC_EN with acc=1, r preloaded with 5 and bm_r=3 → every write is 8. With acc=0 → every write is 3.

Source files
------------

// File: rtl/kyber_pkg.sv
// Kyber constants, coefficient type, Montgomery-domain zeta table and the
// basemul sequencer state encoding shared by the NTT-domain controllers.
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;

  typedef logic signed [15:0] coeff_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_WAIT,
    ST_WRITE,
    ST_FIN
  } seq_state_t;

  // 2^16 * 17^brv7(i) mod q, centred around zero
  localparam int ZETAS [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
     -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,
     -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
      516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
     -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,
      422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
    -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384,
    -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
     -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

endpackage

// File: rtl/poly_basemul_seq_zeta_sel.sv
// Pair index k -> basemul twiddle: ZETAS[64 + k/2], negated for odd k.
module zeta_sel
  import kyber_pkg::*;
(
  input  logic [6:0] k,
  output coeff_t     zeta
);

  logic [6:0] idx;
  coeff_t     z_pos;

  assign idx   = {1'b1, k[6:1]};
  assign z_pos = coeff_t'(ZETAS[idx]);
  assign zeta  = k[0] ? coeff_t'(-z_pos) : z_pos;

endmodule

// File: rtl/poly_basemul_seq.sv
// Walks a polynomial pair through an external basemul, one coefficient pair at a time.
// Optional accumulate-into-result mode is enabled with `define BASEMUL_ACC_EN.
module poly_basemul_seq
  import kyber_pkg::*;
#(
  parameter int BM_LATENCY = 13,
  parameter int NPAIRS     = 128
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef BASEMUL_ACC_EN
  input  logic        acc,
  output logic [6:0]  r_rd_addr,
  input  logic [31:0] r_rd_data,
`endif
  output logic        busy,
  output logic        done,
  output logic [6:0]  a_rd_addr,
  input  logic [31:0] a_rd_data,
  output logic [6:0]  b_rd_addr,
  input  logic [31:0] b_rd_data,
  output logic        r_wr_en,
  output logic [6:0]  r_wr_addr,
  output logic [31:0] r_wr_data,
  output logic        bm_start,
  output logic [31:0] bm_a,
  output logic [31:0] bm_b,
  output logic [15:0] bm_zeta,
  input  logic [31:0] bm_r
);

  localparam int         CW   = $clog2(BM_LATENCY + 1);
  localparam logic [6:0] LAST = 7'(NPAIRS - 1);

  seq_state_t  state;
  logic [6:0]  k;
  logic [CW-1:0] wait_cnt;
  coeff_t      zeta_k;
  logic [31:0] wr_data_next;

  zeta_sel u_zeta_sel (
    .k    (k),
    .zeta (zeta_k)
  );

`ifdef BASEMUL_ACC_EN
  logic        acc_q;
  logic [31:0] r_old;

  // Plain 16-bit wrap per half; reduction happens downstream
  always_comb begin
    wr_data_next = bm_r;
    if (acc_q)
      wr_data_next = {bm_r[31:16] + r_old[31:16], bm_r[15:0] + r_old[15:0]};
  end
`else
  assign wr_data_next = bm_r;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      a_rd_addr <= '0;
      b_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      bm_start  <= 1'b0;
      bm_a      <= '0;
      bm_b      <= '0;
      bm_zeta   <= '0;
`ifdef BASEMUL_ACC_EN
      acc_q     <= 1'b0;
      r_old     <= '0;
      r_rd_addr <= '0;
`endif
    end else begin
      bm_start <= 1'b0;
      r_wr_en  <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_READ;
            k         <= '0;
            busy      <= 1'b1;
            a_rd_addr <= '0;
            b_rd_addr <= '0;
`ifdef BASEMUL_ACC_EN
            acc_q     <= acc;
            r_rd_addr <= '0;
`endif
          end
        end
        // Addresses were set on entry, so the RAMs see k during this cycle
        ST_READ: state <= ST_LOAD;
        ST_LOAD: begin
          bm_a     <= a_rd_data;
          bm_b     <= b_rd_data;
          bm_zeta  <= zeta_k;
          bm_start <= 1'b1;
          wait_cnt <= CW'(BM_LATENCY);
`ifdef BASEMUL_ACC_EN
          r_old    <= r_rd_data;
`endif
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_cnt == CW'(1))
            state <= ST_WRITE;
        end
        ST_WRITE: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= k;
          r_wr_data <= wr_data_next;
          if (k == LAST) begin
            state <= ST_FIN;
            done  <= 1'b1;
          end else begin
            k         <= k + 7'd1;
            a_rd_addr <= k + 7'd1;
            b_rd_addr <= k + 7'd1;
`ifdef BASEMUL_ACC_EN
            r_rd_addr <= k + 7'd1;
`endif
            state     <= ST_READ;
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
